sevenseg_serial_mux: RTL and testbench

- Parametrised multiplexed seven-segment driver for N-digit displays fed through a pair of cascaded 8-bit serial-in/parallel-out shift registers with a storage latch.
- Per digit slot: encodes one hex nibble plus decimal point, serialises {segment byte, select byte} MSB first with a generated shift clock, pulses latch, then holds for the remainder of the refresh slot.
- Sits between the register/data path holding the display value and the board display pins.
- Adds clean reset, a divided shift clock, latch timing, blanking, polarity options, enable and frame status.

---
 rtl/sevenseg_pkg.sv | 47 ++++
 rtl/sevenseg_encoder.sv | 19 +
 rtl/sevenseg_serial_mux.sv | 155 +++++++++++++++
 tb/tb_sevenseg_serial_mux.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types, font table and framing constants for the serial seven-segment driver.
package sevenseg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned SEG_A      = 0;
    localparam int unsigned SEG_G      = 6;
    localparam int unsigned SEG_DP     = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Word shifted out MSB first: segment byte lands in the far register.
    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] sel;
    } frame_t;

    // Hex nibble to segments g..a.
    function automatic logic [6:0] font7(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h3F;
            4'h1:    f = 7'h06;
            4'h2:    f = 7'h5B;
            4'h3:    f = 7'h4F;
            4'h4:    f = 7'h66;
            4'h5:    f = 7'h6D;
            4'h6:    f = 7'h7D;
            4'h7:    f = 7'h07;
            4'h8:    f = 7'h7F;
            4'h9:    f = 7'h6F;
            4'hA:    f = 7'h77;
            4'hB:    f = 7'h7C;
            4'hC:    f = 7'h39;
            4'hD:    f = 7'h5E;
            4'hE:    f = 7'h79;
            default: f = 7'h71;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sevenseg_encoder.sv
// Combinational nibble + dp + blank to active-high segment byte (dp,g..a).
module sevenseg_encoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = '0;
        if (!blank) begin
            seg_c[SEG_G:SEG_A] = font7(nibble);
            seg_c[SEG_DP]      = dp;
        end
    end

endmodule

// File: rtl/sevenseg_serial_mux.sv
// Multiplexed seven-segment driver: per digit slot, shifts {seg,sel} into two
// cascaded SIPO registers, pulses the latch, then holds until the slot ends.
module sevenseg_serial_mux
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 5000,
    parameter int unsigned SCLK_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          SEL_ACTIVE_LOW = 1'b0
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    enable,
    output logic                    ser_data,
    output logic                    ser_clk,
    output logic                    latch,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
    localparam int unsigned PH_W   = $clog2(2 * SCLK_DIV + 1);
    localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

    state_t                  state, state_d;
    logic [SLOT_W-1:0]       slot_cnt, slot_d;
    logic [PH_W-1:0]         ph_cnt, ph_d, ph_inc;
    logic [BIT_W-1:0]        bit_cnt, bit_d;
    logic [FRAME_BITS-1:0]   shreg, shreg_d;
    logic [2:0]              digit_d;
    logic                    ser_data_d, ser_clk_d, latch_d, frame_done_d;

    logic [31:0]             data_pad;
    logic [7:0]              dp_pad, blank_pad;
    logic [3:0]              nibble_c;
    logic [7:0]              seg_raw_c;
    frame_t                  word_c;

    // Zero-extend per-digit inputs so a 3-bit digit index always selects in range.
    assign data_pad  = 32'(data_in);
    assign dp_pad    = 8'(dp_in);
    assign blank_pad = 8'(blank_in);
    assign nibble_c  = data_pad[{digit_idx, 2'b00} +: 4];
    assign ph_inc    = ph_cnt + PH_W'(1);

    sevenseg_encoder u_enc (
        .nibble (nibble_c),
        .dp     (dp_pad[digit_idx]),
        .blank  (blank_pad[digit_idx]),
        .seg_c  (seg_raw_c)
    );

    always_comb begin
        word_c.seg = seg_raw_c ^ {8{SEG_ACTIVE_LOW}};
        word_c.sel = (8'b1 << digit_idx) ^ {8{SEL_ACTIVE_LOW}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            slot_cnt   <= '0;
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            digit_idx  <= '0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            latch      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            slot_cnt   <= slot_d;
            ph_cnt     <= ph_d;
            bit_cnt    <= bit_d;
            shreg      <= shreg_d;
            digit_idx  <= digit_d;
            ser_data   <= ser_data_d;
            ser_clk    <= ser_clk_d;
            latch      <= latch_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d      = state;
        slot_d       = slot_cnt + SLOT_W'(1);
        ph_d         = ph_cnt;
        bit_d        = bit_cnt;
        shreg_d      = shreg;
        digit_d      = digit_idx;
        ser_data_d   = 1'b0;
        ser_clk_d    = 1'b0;
        latch_d      = 1'b0;
        frame_done_d = 1'b0;

        case (state)
            IDLE: begin
                slot_d = '0;
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                shreg_d    = word_c;
                slot_d     = SLOT_W'(1);
                ph_d       = '0;
                bit_d      = '0;
                ser_data_d = word_c.seg[7];
                state_d    = SHIFT;
            end
            SHIFT: begin
                ser_data_d = shreg[FRAME_BITS-1];
                if (ph_cnt == PH_W'(2 * SCLK_DIV - 1)) begin
                    ph_d = '0;
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        ser_data_d = 1'b0;
                        latch_d    = 1'b1;
                        state_d    = LATCH;
                    end else begin
                        bit_d      = bit_cnt + BIT_W'(1);
                        shreg_d    = {shreg[FRAME_BITS-2:0], 1'b0};
                        ser_data_d = shreg[FRAME_BITS-2];
                    end
                end else begin
                    ph_d      = ph_inc;
                    ser_clk_d = (ph_inc >= PH_W'(SCLK_DIV));
                end
            end
            LATCH: begin
                if (ph_cnt == PH_W'(SCLK_DIV - 1)) begin
                    ph_d    = '0;
                    state_d = HOLD;
                end else begin
                    ph_d    = ph_inc;
                    latch_d = 1'b1;
                end
            end
            HOLD: begin
                if (slot_cnt == SLOT_W'(REFRESH_DIV - 2) && digit_idx == 3'(NUM_DIGITS - 1))
                    frame_done_d = 1'b1;
                if (slot_cnt == SLOT_W'(REFRESH_DIV - 1)) begin
                    slot_d  = '0;
                    digit_d = (digit_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
                    state_d = enable ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sevenseg_serial_mux.sv
// Directed bench: a default-parameter instance for slot/frame timing and a fast
// active-low-segment instance for bit timing, reset abort, polarity and enable.
module tb_sevenseg_serial_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: defaults (N=4, REFRESH_DIV=5000, SCLK_DIV=4)
    logic        a_rst = 1'b1, a_enable = 1'b0;
    logic [15:0] a_data = '0;
    logic [3:0]  a_dp = '0, a_blank = '0;
    logic        a_ser_data, a_ser_clk, a_latch, a_frame_done;
    logic [2:0]  a_digit_idx;

    sevenseg_serial_mux u_a (
        .clk(clk), .rst(a_rst), .data_in(a_data), .dp_in(a_dp), .blank_in(a_blank),
        .enable(a_enable), .ser_data(a_ser_data), .ser_clk(a_ser_clk), .latch(a_latch),
        .digit_idx(a_digit_idx), .frame_done(a_frame_done)
    );

    // Instance B: fast slot, SCLK_DIV=1, active-low segments
    logic        b_rst = 1'b1, b_enable = 1'b0;
    logic [15:0] b_data = '0;
    logic [3:0]  b_dp = '0, b_blank = '0;
    logic        b_ser_data, b_ser_clk, b_latch, b_frame_done;
    logic [2:0]  b_digit_idx;

    sevenseg_serial_mux #(
        .NUM_DIGITS(4), .REFRESH_DIV(40), .SCLK_DIV(1), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) u_b (
        .clk(clk), .rst(b_rst), .data_in(b_data), .dp_in(b_dp), .blank_in(b_blank),
        .enable(b_enable), .ser_data(b_ser_data), .ser_clk(b_ser_clk), .latch(b_latch),
        .digit_idx(b_digit_idx), .frame_done(b_frame_done)
    );

    // Shift-register model for A: capture on ser_clk rise, store on latch rise.
    logic [15:0] a_sh = '0;
    logic        a_clk_q = 1'b0, a_latch_q = 1'b0;
    logic [15:0] a_words[$];
    int          a_lat_cyc[$];
    logic [2:0]  a_lat_idx[$];
    int          a_fd_cyc[$];

    always @(negedge clk) begin
        if (a_rst) a_sh = '0;
        else begin
            if (a_ser_clk && !a_clk_q) a_sh = {a_sh[14:0], a_ser_data};
            if (a_latch && !a_latch_q) begin
                a_words.push_back(a_sh);
                a_lat_cyc.push_back(cyc);
                a_lat_idx.push_back(a_digit_idx);
            end
            if (a_frame_done) a_fd_cyc.push_back(cyc);
        end
        a_clk_q   = a_ser_clk;
        a_latch_q = a_latch;
    end

    // Shift-register model for B plus timing observations.
    logic [15:0] b_sh = '0;
    logic        b_clk_q = 1'b0, b_latch_q = 1'b0, b_data_q = 1'b0;
    int          b_edges = 0, b_last_rise = 0, b_per_bad = 0, b_viol = 0, b_lat_w = 0;
    logic [15:0] b_words[$];
    int          b_lat_cyc[$];
    logic [2:0]  b_lat_idx[$];
    int          b_edges_q[$];
    int          b_lat_w_q[$];

    always @(negedge clk) begin
        if (b_rst) begin
            b_sh    = '0;
            b_edges = 0;
        end else begin
            if (b_ser_clk && b_ser_data !== b_data_q) b_viol++;
            if (b_ser_clk && !b_clk_q) begin
                if (b_edges > 0 && cyc - b_last_rise != 2) b_per_bad++;
                b_last_rise = cyc;
                b_sh = {b_sh[14:0], b_ser_data};
                b_edges++;
            end
            if (b_latch && !b_latch_q) begin
                b_words.push_back(b_sh);
                b_lat_cyc.push_back(cyc);
                b_lat_idx.push_back(b_digit_idx);
                b_edges_q.push_back(b_edges);
                b_edges = 0;
                b_lat_w = 0;
            end
            if (b_latch) b_lat_w++;
            if (!b_latch && b_latch_q) b_lat_w_q.push_back(b_lat_w);
        end
        b_clk_q   = b_ser_clk;
        b_latch_q = b_latch;
        b_data_q  = b_ser_data;
    end

    task automatic test_reset();
        a_rst = 1'b1;
        b_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_ser_data, a_ser_clk, a_latch, a_digit_idx, a_frame_done} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %b expected 0000000",
                     {a_ser_data, a_ser_clk, a_latch, a_digit_idx, a_frame_done});
        end
        n_cmp++;
        if ({b_ser_data, b_ser_clk, b_latch, b_digit_idx, b_frame_done} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %b expected 0000000",
                     {b_ser_data, b_ser_clk, b_latch, b_digit_idx, b_frame_done});
        end
        a_data   = 16'h10A8;
        a_enable = 1'b1;
        a_rst    = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        int nlat;
        b_data   = 16'h8882;
        b_dp     = 4'b0010;
        b_blank  = 4'b0100;
        b_enable = 1'b1;
        b_rst    = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_edges == 6 && b_ser_clk) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL reset_mid_wait: bit 5 not reached, edges %0d expected 6", b_edges);
        end
        // Bit 5 of word A401 is 1, so the abort must visibly pull ser_data low.
        n_cmp++;
        if (b_ser_data !== 1'b1) begin
            n_bad++;
            $display("FAIL bit5_value: got %b expected 1", b_ser_data);
        end
        nlat = b_words.size();
        b_rst = 1'b1;
        #1;
        n_cmp++;
        if ({b_ser_data, b_ser_clk, b_latch, b_digit_idx, b_frame_done} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %b expected 0000000",
                     {b_ser_data, b_ser_clk, b_latch, b_digit_idx, b_frame_done});
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (b_words.size() != nlat) begin
            n_bad++;
            $display("FAIL reset_no_latch: latches %0d expected %0d", b_words.size(), nlat);
        end
        b_rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_words.size() > nlat) ok = 1'b1;
        end
        n_cmp++;
        if (!ok || b_lat_idx[0] !== 3'd0 || b_words[0] !== 16'hA401) begin
            n_bad++;
            $display("FAIL first_after_reset: word %h idx %0d expected A401 idx 0",
                     b_words[0], b_lat_idx[0]);
        end
    endtask

    task automatic test_bit_timing();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b_lat_w_q[0] != 1) begin
            n_bad++;
            $display("FAIL latch_width: got %0d expected 1", b_lat_w_q[0]);
        end
        n_cmp++;
        if (b_edges_q[0] != 16) begin
            n_bad++;
            $display("FAIL sclk_edges: got %0d expected 16", b_edges_q[0]);
        end
        n_cmp++;
        if (b_per_bad != 0) begin
            n_bad++;
            $display("FAIL sclk_period: %0d rises not 2 cycles apart, expected 0", b_per_bad);
        end
        n_cmp++;
        if (b_viol != 0) begin
            n_bad++;
            $display("FAIL data_stable: %0d changes while ser_clk high, expected 0", b_viol);
        end
    endtask

    task automatic test_input_change();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_words.size() == 1 && b_digit_idx == 3'd1 && b_edges == 3) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL change_wait: digit1 shift not seen, idx %0d expected 1", b_digit_idx);
        end
        b_data = 16'h8802;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_words.size() >= 6) ok = 1'b1;
        end
        n_cmp++;
        if (!ok || b_words[1] !== 16'h0002) begin
            n_bad++;
            $display("FAIL word_unchanged: got %h expected 0002", b_words[1]);
        end
        n_cmp++;
        if (b_words[4] !== 16'hA401) begin
            n_bad++;
            $display("FAIL word_d0_frame2: got %h expected A401", b_words[4]);
        end
        n_cmp++;
        if (b_words[5] !== 16'h4002 || b_lat_idx[5] !== 3'd1) begin
            n_bad++;
            $display("FAIL word_new_value: got %h idx %0d expected 4002 idx 1",
                     b_words[5], b_lat_idx[5]);
        end
    endtask

    task automatic test_polarity_blank();
        n_cmp++;
        if (b_words[2] !== 16'hFF04) begin
            n_bad++;
            $display("FAIL blank_inverted: got %h expected FF04", b_words[2]);
        end
        n_cmp++;
        if (b_words[3] !== 16'h8008) begin
            n_bad++;
            $display("FAIL seg_inverted: got %h expected 8008", b_words[3]);
        end
        for (int i = 1; i < 6; i++) begin
            n_cmp++;
            if (b_lat_cyc[i] - b_lat_cyc[i-1] != 40) begin
                n_bad++;
                $display("FAIL slot_len_b[%0d]: got %0d expected 40", i, b_lat_cyc[i] - b_lat_cyc[i-1]);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        repeat (3) @(negedge clk);
        b_enable = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_digit_idx == 3'd2) ok = 1'b1;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (!ok || {b_ser_data, b_ser_clk, b_latch, b_digit_idx} !== 6'b000_010) begin
            n_bad++;
            $display("FAIL idle_after_drop: got %b expected 000010",
                     {b_ser_data, b_ser_clk, b_latch, b_digit_idx});
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (b_words.size() != 6) begin
            n_bad++;
            $display("FAIL idle_no_shift: latches %0d expected 6", b_words.size());
        end
        b_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (b_words.size() >= 7) ok = 1'b1;
        end
        n_cmp++;
        if (!ok || b_lat_idx[6] !== 3'd2 || b_words[6] !== 16'hFF04) begin
            n_bad++;
            $display("FAIL resume_digit: word %h idx %0d expected FF04 idx 2",
                     b_words[6], b_lat_idx[6]);
        end
    endtask

    task automatic test_default_frames();
        bit ok;
        logic [15:0] exp_w[4];
        exp_w = '{16'h7F01, 16'h7702, 16'h3F04, 16'h0608};
        ok = 1'b0;
        for (int i = 0; i < 50000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (a_fd_cyc.size() >= 2) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL frame_wait: frame_done pulses %0d expected 2", a_fd_cyc.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a_words[i] !== exp_w[i] || a_lat_idx[i] !== 3'(i)) begin
                n_bad++;
                $display("FAIL word_a[%0d]: got %h idx %0d expected %h idx %0d",
                         i, a_words[i], a_lat_idx[i], exp_w[i], i);
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (a_lat_cyc[i] - a_lat_cyc[i-1] != 5000) begin
                n_bad++;
                $display("FAIL slot_len_a[%0d]: got %0d expected 5000", i, a_lat_cyc[i] - a_lat_cyc[i-1]);
            end
        end
        n_cmp++;
        if (a_fd_cyc[1] - a_fd_cyc[0] != 20000) begin
            n_bad++;
            $display("FAIL frame_period: got %0d expected 20000", a_fd_cyc[1] - a_fd_cyc[0]);
        end
        // Latch rises at slot cycle 129, frame_done sits on slot cycle 4999.
        n_cmp++;
        if (a_fd_cyc[0] - a_lat_cyc[3] != 4870) begin
            n_bad++;
            $display("FAIL frame_done_pos: got %0d expected 4870", a_fd_cyc[0] - a_lat_cyc[3]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_shift();
        test_bit_timing();
        test_input_change();
        test_polarity_blank();
        test_enable_drop();
        test_default_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
